seq_frame_tx: RTL

// - Serial frame transmitter; the sending end of the "101" sequence-detector link.
// - Accepts a parallel word, emits preamble 1,0,1, then the payload MSB-first

---
 rtl/seq_frame_pkg.sv | 28 ++
 rtl/seq_stuff_tracker.sv | 39 +++
 rtl/seq_frame_tx.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/seq_frame_pkg.sv
// Shared definitions for the "101" frame transmitter.
// Holds the frame state encoding, the preamble pattern, the history pattern
// that forces a stuff bit, and a helper telling which states feed the
// stuffing history.
package seq_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_STUFF,
    ST_TAIL
  } state_t;

  // Sent MSB first; its last two bits "01" seed the stuffing history.
  localparam logic [2:0] PREAMBLE = 3'b101;

  // Once the last two line bits read "10", a following 1 would complete "101",
  // so a 0 is forced onto the line instead.
  localparam logic [1:0] STUFF_PATTERN = 2'b10;

  // The history only follows bits emitted in the preamble, payload and stuff
  // phases; idle and guard zeros clear it.
  function automatic logic is_tracked(input state_t s);
    return (s == ST_PRE) || (s == ST_DATA) || (s == ST_STUFF);
  endfunction

endpackage

// File: rtl/seq_stuff_tracker.sv
// Line history for bit stuffing.
// Keeps the last two bits placed on the serial line and asks for a stuff bit
// when the payload bit just emitted completed the "10" pattern.
// Ports:
//   clk_i     - clock, rising edge
//   reset_i   - asynchronous active-high reset, clears the history
//   track_en  - the bit on line_bit is the next line bit of a tracked phase
//   line_bit  - the bit that goes onto the line at this edge
//   check_en  - the current line bit is a payload bit
//   stuff_req - the next line cycle must be a stuff bit
module seq_stuff_tracker
  import seq_frame_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic track_en,
  input  logic line_bit,
  input  logic check_en,
  output logic stuff_req
);

  logic [1:0] history;

  // The history mirrors the line: {previous bit, current bit}. Outside the
  // tracked phases it is held at 00 so each frame starts from a clean slate.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      history <= 2'b00;
    end else if (track_en) begin
      history <= {history[0], line_bit};
    end else begin
      history <= 2'b00;
    end
  end

  // Stuffing is only ever triggered by a payload bit, never by the preamble.
  assign stuff_req = check_en && (history == STUFF_PATTERN);

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter feeding a Mealy "101" detector.
// A frame is the preamble 1,0,1, the payload MSB first with a 0 stuffed after
// every payload bit that leaves "10" on the line, then TAIL_LEN guard zeros.
// This keeps "101" on the line only at the last preamble bit.
// Ports:
//   clk_i    - clock, rising edge
//   reset_i  - asynchronous active-high reset; abandons any frame in flight
//   data_i   - payload word, captured only at the handshake
//   valid_i  - payload request
//   ready_o  - high while idle; handshake is valid_i & ready_o at a rising edge
//   out_o    - registered serial line, 0 when idle
//   busy_o   - high from the first preamble bit to the last guard bit
//   done_o   - high during the last guard bit
module seq_frame_tx
  import seq_frame_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int TAIL_LEN = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             out_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int TAIL_W = $clog2(TAIL_LEN);
  localparam logic [CNT_W-1:0]  BITS_INIT = CNT_W'(WIDTH);
  localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(TAIL_LEN - 1);

  state_t            state;
  state_t            state_next;
  logic [WIDTH-1:0]  shift_reg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [1:0]        pre_idx;
  logic [1:0]        pre_rest;
  logic [TAIL_W-1:0] tail_cnt;
  logic              handshake;
  logic              stuff_req;
  logic              line_next;
  logic              track_en;
  logic              bits_done;
  logic              pre_last;
  logic              tail_last;

  assign handshake = valid_i && (state == ST_IDLE);
  // bit_cnt holds the payload bits still to be emitted after the current one.
  assign bits_done = (bit_cnt == '0);
  assign pre_last  = (pre_idx == 2'd2);
  assign tail_last = (tail_cnt == TAIL_LAST);

  // State register: the state names the phase of the bit now on out_o.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A stuff bit returns to the payload unless the payload
  // is exhausted, in which case the guard zeros follow directly.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (handshake) state_next = ST_PRE;
      ST_PRE:   if (pre_last)  state_next = ST_DATA;
      ST_DATA: begin
        if (stuff_req) begin
          state_next = ST_STUFF;
        end else if (bits_done) begin
          state_next = ST_TAIL;
        end
      end
      ST_STUFF: state_next = bits_done ? ST_TAIL : ST_DATA;
      ST_TAIL:  if (tail_last) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output logic: line_next is the bit registered onto out_o at this edge.
  // Only preamble and payload bits can be 1; stuff, guard and idle are 0.
  always_comb begin
    line_next = 1'b0;
    case (state_next)
      ST_PRE:  line_next = (state == ST_IDLE) ? PREAMBLE[2] : pre_rest[1];
      ST_DATA: line_next = shift_reg[WIDTH-1];
      default: line_next = 1'b0;
    endcase
    track_en = is_tracked(state_next);
    ready_o  = (state == ST_IDLE);
    busy_o   = (state != ST_IDLE);
    done_o   = (state == ST_TAIL) && tail_last;
  end

  // Datapath: the payload shifts out MSB first and the bit counter steps only
  // when a payload bit is emitted, so stuff cycles leave it untouched.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      out_o     <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      pre_idx   <= '0;
      pre_rest  <= '0;
      tail_cnt  <= '0;
    end else begin
      out_o <= line_next;
      if (handshake) begin
        shift_reg <= data_i;
        bit_cnt   <= BITS_INIT;
        pre_idx   <= '0;
        pre_rest  <= PREAMBLE[1:0];
      end else begin
        if (state == ST_PRE) begin
          pre_idx  <= pre_idx + 2'd1;
          pre_rest <= {pre_rest[0], 1'b0};
        end
        if (state_next == ST_DATA) begin
          shift_reg <= shift_reg << 1;
          bit_cnt   <= bit_cnt - 1'b1;
        end
      end
      tail_cnt <= (state == ST_TAIL) ? tail_cnt + 1'b1 : '0;
    end
  end

  seq_stuff_tracker u_stuff_tracker (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .track_en  (track_en),
    .line_bit  (line_next),
    .check_en  (state == ST_DATA),
    .stuff_req (stuff_req)
  );

endmodule
